// File: rtl/uart_rx_frame.sv
// UART receiver with configurable frame format, 3-sample majority voting and
// a valid/ready holding register carrying parity/framing sideband flags.
`timescale 1ns/1ps
module uart_rx_frame #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DIV_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DIV_W-1:0]     baud_div,
    input  logic                 rs232_rx,
    output logic                 busy,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int unsigned SC_W = $clog2(OVERSAMPLE);
    localparam int unsigned BC_W = $clog2(DATA_BITS);
    localparam int unsigned M    = OVERSAMPLE / 2;
    localparam logic        ODD  = (PARITY == 2);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t                 state, state_nx;
    logic                   rx_meta, rx_s, rx_d;
    logic [DIV_W-1:0]       cnt, div_q;
    logic [SC_W-1:0]        sc;
    logic [BC_W-1:0]        bit_cnt;
    logic                   stop_cnt;
    logic                   s0, s1;
    logic [DATA_BITS-1:0]   shreg;
    logic                   par_acc, fe_acc;

    logic start_det, tick, vote, at_vote, at_end, last_data, last_stop, done;

    assign start_det = (state == S_IDLE) && rx_d && !rx_s;
    assign tick      = (state != S_IDLE) && (cnt == div_q);
    // third sample is the live synchronised line at sc = M+1
    assign vote      = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
    assign at_vote   = tick && (sc == SC_W'(M + 1));
    assign at_end    = tick && (sc == SC_W'(OVERSAMPLE - 1));
    assign last_data = (bit_cnt == BC_W'(DATA_BITS - 1));
    assign last_stop = (STOP_BITS == 1) ? 1'b1 : stop_cnt;
    assign done      = (state == S_STOP) && at_vote && last_stop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx != S_IDLE);
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (start_det) state_nx = S_START;
            S_START: begin
                if (at_vote && vote)  state_nx = S_IDLE;
                else if (at_end)      state_nx = S_DATA;
            end
            S_DATA:   if (at_end && last_data) state_nx = (PARITY != 0) ? S_PARITY : S_STOP;
            S_PARITY: if (at_end) state_nx = S_STOP;
            S_STOP:   if (done)   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // synchroniser, tick/bit timing, shift register and holding register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta    <= 1'b1;
            rx_s       <= 1'b1;
            rx_d       <= 1'b1;
            cnt        <= '0;
            div_q      <= '0;
            sc         <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            s0         <= 1'b0;
            s1         <= 1'b0;
            shreg      <= '0;
            par_acc    <= 1'b0;
            fe_acc     <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            rx_meta <= rs232_rx;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
            overrun <= 1'b0;

            if (state == S_IDLE) begin
                cnt      <= '0;
                sc       <= '0;
                bit_cnt  <= '0;
                stop_cnt <= 1'b0;
                par_acc  <= 1'b0;
                fe_acc   <= 1'b0;
                if (start_det) div_q <= baud_div;
            end else begin
                cnt <= tick ? '0 : cnt + DIV_W'(1);
                if (tick) begin
                    sc <= (sc == SC_W'(OVERSAMPLE - 1)) ? '0 : sc + SC_W'(1);
                    if (sc == SC_W'(M - 1)) s0 <= rx_s;
                    if (sc == SC_W'(M))     s1 <= rx_s;
                end
                if (at_vote) begin
                    case (state)
                        S_DATA:   shreg   <= {vote, shreg[DATA_BITS-1:1]};
                        S_PARITY: par_acc <= (^shreg) ^ vote ^ ODD;
                        S_STOP:   if (!vote) fe_acc <= 1'b1;
                        default:  ;
                    endcase
                end
                if (at_end) begin
                    if (state == S_DATA) bit_cnt  <= bit_cnt + BC_W'(1);
                    if (state == S_STOP) stop_cnt <= 1'b1;
                end
            end

            // a completing frame wins over a plain handshake; full and stalled drops it
            if (done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data    <= shreg;
                    parity_err <= par_acc;
                    frame_err  <= fe_acc | !vote;
                    rx_valid   <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: an 8N1 instance and an 8E1 instance at
// baud_div=1 (32 clk per bit), checked with immediate assertions.
`timescale 1ns/1ps
module tb_uart_rx_frame;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] baud_div;
    logic        rx_a, rx_b, rdy_a, rdy_b;
    logic        busy_a, valid_a, pe_a, fe_a, ovr_a;
    logic        busy_b, valid_b, pe_b, fe_b, ovr_b;
    logic [7:0]  data_a, data_b;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    int         acc_a = 0, vhigh_a = 0, ovr_cnt_a = 0, acc_b = 0;
    logic [7:0] last_d_a = '0, last_d_b = '0;
    logic       last_pe_a = 1'b0, last_fe_a = 1'b0, last_pe_b = 1'b0, last_fe_b = 1'b0;

    always #5 clk = ~clk;

    uart_rx_frame #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(16), .DIV_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .rs232_rx(rx_a), .busy(busy_a),
        .rx_data(data_a), .rx_valid(valid_a), .rx_ready(rdy_a),
        .parity_err(pe_a), .frame_err(fe_a), .overrun(ovr_a)
    );

    uart_rx_frame #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .OVERSAMPLE(16), .DIV_W(16)) dut_p (
        .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .rs232_rx(rx_b), .busy(busy_b),
        .rx_data(data_b), .rx_valid(valid_b), .rx_ready(rdy_b),
        .parity_err(pe_b), .frame_err(fe_b), .overrun(ovr_b)
    );

    // handshake monitors sample on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (valid_a) vhigh_a++;
        if (ovr_a) ovr_cnt_a++;
        if (valid_a && rdy_a) begin
            acc_a++;
            last_d_a  = data_a;
            last_pe_a = pe_a;
            last_fe_a = fe_a;
        end
        if (valid_b && rdy_b) begin
            acc_b++;
            last_d_b  = data_b;
            last_pe_b = pe_b;
            last_fe_b = fe_b;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // bit 0 of fr goes on the line first, each bit held 32 clk
    task automatic send(input logic [11:0] fr, input int n, input bit sel);
        for (int i = 0; i < n; i++) begin
            if (sel) rx_b = fr[i];
            else     rx_a = fr[i];
            idle(32);
        end
    endtask

    function automatic logic [11:0] f8(input logic [7:0] d, input logic stp);
        return {3'b111, stp, d, 1'b0};
    endfunction

    function automatic logic [11:0] f8p(input logic [7:0] d, input logic p);
        return {2'b11, 1'b1, p, d, 1'b0};
    endfunction

    initial begin
        int acc0, v0, o0;
        rst_n    = 1'b0;
        baud_div = 16'd1;
        rx_a     = 1'b1;
        rx_b     = 1'b1;
        rdy_a    = 1'b1;
        rdy_b    = 1'b1;
        idle(3);
        chk("rst_busy", busy_a, 0);
        chk("rst_data", data_a, 0);
        chk("rst_valid", valid_a, 0);
        chk("rst_pe", pe_a, 0);
        chk("rst_fe", fe_a, 0);
        chk("rst_ovr", ovr_a, 0);
        rst_n = 1'b1;
        idle(40);

        // 8N1 0xA5: busy drops part-way through the stop bit
        send(f8(8'hA5, 1'b1), 9, 1'b0);
        rx_a = 1'b1;
        idle(16);
        chk("t1_busy_mid_stop", busy_a, 1);
        idle(10);
        chk("t1_busy_after", busy_a, 0);
        idle(38);
        chk("t1_acc", acc_a, 1);
        chk("t1_data", last_d_a, 8'hA5);
        chk("t1_pe", last_pe_a, 0);
        chk("t1_fe", last_fe_a, 0);
        chk("t1_pulse_width", vhigh_a, 1);

        // even parity: 0x37 has five ones, so parity bit 0 is wrong
        send(f8p(8'h37, 1'b0), 11, 1'b1);
        idle(32);
        chk("t2_acc", acc_b, 1);
        chk("t2_data", last_d_b, 8'h37);
        chk("t2_pe", last_pe_b, 1);
        chk("t2_fe", last_fe_b, 0);
        send(f8p(8'h03, 1'b0), 11, 1'b1);
        idle(32);
        chk("t2_clean_data", last_d_b, 8'h03);
        chk("t2_clean_pe", last_pe_b, 0);
        chk("t2_busy_b", busy_b, 0);

        // stop bit low, then line recovers for a clean 0x11
        send(f8(8'h5A, 1'b0), 10, 1'b0);
        rx_a = 1'b1;
        idle(32);
        chk("t3_acc", acc_a, 2);
        chk("t3_data", last_d_a, 8'h5A);
        chk("t3_fe", last_fe_a, 1);
        chk("t3_pe", last_pe_a, 0);
        send(f8(8'h11, 1'b1), 10, 1'b0);
        idle(32);
        chk("t3_next_data", last_d_a, 8'h11);
        chk("t3_next_fe", last_fe_a, 0);

        // 8-clk glitch is a false start
        v0 = vhigh_a;
        rx_a = 1'b0;
        idle(8);
        rx_a = 1'b1;
        idle(4);
        chk("t4_busy_started", busy_a, 1);
        idle(16);
        chk("t4_busy_rejected", busy_a, 0);
        idle(40);
        chk("t4_no_valid", vhigh_a, v0);
        send(f8(8'h3C, 1'b1), 10, 1'b0);
        idle(32);
        chk("t4_data", last_d_a, 8'h3C);

        // stalled consumer, two back-to-back frames
        o0    = ovr_cnt_a;
        rdy_a = 1'b0;
        send(f8(8'h01, 1'b1), 10, 1'b0);
        send(f8(8'h02, 1'b1), 10, 1'b0);
        idle(32);
        chk("t5_valid_held", valid_a, 1);
        chk("t5_data_held", data_a, 8'h01);
        chk("t5_overrun_once", ovr_cnt_a - o0, 1);
        rdy_a = 1'b1;
        idle(2);
        chk("t5_valid_cleared", valid_a, 0);
        chk("t5_data_kept", data_a, 8'h01);
        chk("t5_accepted", last_d_a, 8'h01);

        // reset in the middle of data bit 4, held until the aborted frame ends
        acc0 = acc_a;
        fork
            send(f8(8'h96, 1'b1), 10, 1'b0);
            begin
                idle(5 * 32 + 16);
                chk("t6_busy_pre", busy_a, 1);
                rst_n = 1'b0;
                #1;
                chk("t6_busy", busy_a, 0);
                chk("t6_data", data_a, 0);
                chk("t6_valid", valid_a, 0);
                chk("t6_pe", pe_a, 0);
                chk("t6_fe", fe_a, 0);
                chk("t6_ovr", ovr_a, 0);
            end
        join
        idle(2);
        rst_n = 1'b1;
        idle(32);
        chk("t6_no_frame", acc_a, acc0);
        send(f8(8'hC3, 1'b1), 10, 1'b0);
        idle(32);
        chk("t6_acc", acc_a, acc0 + 1);
        chk("t6_after_data", last_d_a, 8'hC3);
        chk("t6_after_fe", last_fe_a, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
